// File: rtl/sram_serial_loader_if.sv
// Write-side and downstream serial-controller signals of the SRAM serial loader.
// The master drives requests and RDY; the slave (the loader) drives status and serial outputs.
interface sram_serial_loader_if #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9
);
  logic                         WR_EN;
  logic [MEMORY_ADDR_WIDTH-1:0] WR_ADDR;
  logic [MEMORY_DATA_WIDTH-1:0] WR_DATA;
  logic                         FULL;
  logic                         EMPTY;
  logic                         IO_BGN;
  logic                         LOAD_N;
  logic                         SI;
  logic                         RDY;
  logic                         BUSY;
  logic                         WORD_DONE;
  logic [1:0]                   ERR;
  logic [9:0]                   WORD_CNT;

  modport master (
    output WR_EN, WR_ADDR, WR_DATA, RDY,
    input  FULL, EMPTY, IO_BGN, LOAD_N, SI, BUSY, WORD_DONE, ERR, WORD_CNT
  );

  modport slave (
    input  WR_EN, WR_ADDR, WR_DATA, RDY,
    output FULL, EMPTY, IO_BGN, LOAD_N, SI, BUSY, WORD_DONE, ERR, WORD_CNT
  );
endinterface

// File: rtl/sram_serial_loader.sv
// Buffers {addr,data} words in a 4-entry FIFO and serialises each one LSB first to a
// downstream SRAM I/O controller, waiting for RDY (with timeout) and restarting it per word.
module sram_serial_loader #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int RDY_TIMEOUT       = 8
) (
  input logic                 CLK,
  input logic                 BGN,
  sram_serial_loader_if.slave bus
);

  localparam int FW = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH;
  localparam int CW = $clog2(FW);
  localparam int TW = $clog2(RDY_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, START, SHIFT, WAIT_RDY, RESTART} state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] fifo_mem [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    occ, occ_nxt;
  logic          full, empty;
  logic          push, pop, drop;
  logic [FW-1:0] sreg;
  logic [CW-1:0] bcnt, bcnt_nxt;
  logic [TW-1:0] wcnt, wcnt_nxt;
  logic          shift_en, timeout;
  logic          load_n_nxt, si_nxt, io_bgn_nxt, busy_nxt, done_nxt;
  logic          load_n_r, si_r, io_bgn_r, busy_r, done_r;
  logic [1:0]    err_r;
  logic [9:0]    cnt_r;

  assign push    = bus.WR_EN && !full;
  assign drop    = bus.WR_EN && full;
  assign pop     = (state == IDLE) && !empty;
  assign occ_nxt = occ + 3'(push) - 3'(pop);

  always_ff @(posedge CLK or negedge BGN) begin
    if (!BGN) begin
      occ    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      occ   <= occ_nxt;
      full  <= (occ_nxt == 3'd4);
      empty <= (occ_nxt == 3'd0);
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
    end
  end

  // Storage and shifter hold no control meaning, so they are left out of reset.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= {bus.WR_ADDR, bus.WR_DATA};
    if (pop)           sreg <= fifo_mem[rd_ptr];
    else if (shift_en) sreg <= sreg >> 1;
  end

  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    wcnt_nxt  = wcnt;
    shift_en  = 1'b0;
    si_nxt    = 1'b0;
    done_nxt  = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: if (!empty) state_nxt = START;
      START: begin
        state_nxt = SHIFT;
        si_nxt    = sreg[0];
        shift_en  = 1'b1;
        bcnt_nxt  = '0;
      end
      SHIFT: begin
        if (bcnt == CW'(FW - 1)) begin
          state_nxt = WAIT_RDY;
          wcnt_nxt  = '0;
        end else begin
          si_nxt   = sreg[0];
          shift_en = 1'b1;
          bcnt_nxt = bcnt + 1'b1;
        end
      end
      WAIT_RDY: begin
        // RDY in the final permitted cycle still wins over the timeout.
        if (bus.RDY) begin
          state_nxt = RESTART;
          done_nxt  = 1'b1;
        end else if (wcnt == TW'(RDY_TIMEOUT - 1)) begin
          state_nxt = RESTART;
          timeout   = 1'b1;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      RESTART: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    load_n_nxt = (state_nxt != START);
    io_bgn_nxt = (state_nxt != RESTART);
    busy_nxt   = (state_nxt != IDLE);
  end

  always_ff @(posedge CLK or negedge BGN) begin
    if (!BGN) begin
      state    <= IDLE;
      bcnt     <= '0;
      wcnt     <= '0;
      load_n_r <= 1'b1;
      si_r     <= 1'b0;
      io_bgn_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 2'b00;
      cnt_r    <= '0;
    end else begin
      state    <= state_nxt;
      bcnt     <= bcnt_nxt;
      wcnt     <= wcnt_nxt;
      load_n_r <= load_n_nxt;
      si_r     <= si_nxt;
      io_bgn_r <= io_bgn_nxt;
      busy_r   <= busy_nxt;
      done_r   <= done_nxt;
      err_r    <= err_r | {drop, timeout};
      cnt_r    <= cnt_r + 10'(done_nxt);
    end
  end

  assign bus.FULL      = full;
  assign bus.EMPTY     = empty;
  assign bus.IO_BGN    = io_bgn_r;
  assign bus.LOAD_N    = load_n_r;
  assign bus.SI        = si_r;
  assign bus.BUSY      = busy_r;
  assign bus.WORD_DONE = done_r;
  assign bus.ERR       = err_r;
  assign bus.WORD_CNT  = cnt_r;

endmodule

// File: doc/sram_serial_loader.md
SRAM_SERIAL_LOADER -- requirements
Module: sram_serial_loader

Interface
REQ-001 SHALL have parameter MEMORY_DATA_WIDTH, default 8, SRAM data width.
REQ-002 SHALL have parameter MEMORY_ADDR_WIDTH, default 9, SRAM address width; frame width FW = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH (17).
REQ-003 SHALL have parameter RDY_TIMEOUT, default 8, maximum cycles spent waiting for RDY.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 BGN  input  1  reset, asynchronous, active-low.
REQ-006 WR_EN  input  1  push request for one word.
REQ-007 WR_ADDR  input  MEMORY_ADDR_WIDTH  target SRAM address.
REQ-008 WR_DATA  input  MEMORY_DATA_WIDTH  target SRAM data.
REQ-009 FULL / EMPTY  output  1 each  FIFO status.
REQ-010 IO_BGN  output  1  active-low restart for the downstream serial I/O controller.
REQ-011 LOAD_N  output  1  active-low start-of-frame strobe to the downstream controller.
REQ-012 SI  output  1  serial frame bit.
REQ-013 RDY  input  1  downstream write-complete flag.
REQ-014 BUSY  output  1  high when the state is not IDLE.
REQ-015 WORD_DONE  output  1  one-cycle pulse per word confirmed written.
REQ-016 ERR  output  2  sticky flags: [0] RDY timeout, [1] FIFO overflow.
REQ-017 WORD_CNT  output  10  count of confirmed words; wraps 1023->0.

Function
REQ-018 SHALL buffer words in a 4-entry FIFO of {WR_ADDR, WR_DATA}; push when WR_EN=1 and FULL=0.
REQ-019 WR_EN=1 while FULL=1 SHALL drop the word and set ERR[1], even if a pop occurs in the same cycle.
REQ-020 FULL/EMPTY SHALL be registered and reflect occupancy after the current edge; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-021 The FSM SHALL have states IDLE, START, SHIFT, WAIT_RDY, RESTART.
REQ-022 IDLE: if EMPTY=0, pop the head into an FW-bit shift register and go to START; otherwise stay.
REQ-023 START: lasts exactly one cycle; LOAD_N=0; go to SHIFT.
REQ-024 SHIFT: lasts exactly FW cycles; SI = shift register bit 0; shift right once per cycle; go to WAIT_RDY after bit FW-1.
REQ-025 Frame order SHALL be LSB first: data[0..MDW-1], then addr[0..MAW-1].
REQ-026 Outside SHIFT, SI SHALL be 0; outside START, LOAD_N SHALL be 1.
REQ-027 WAIT_RDY: RDY sampled 1 -> RESTART with WORD_DONE=1 for that RESTART cycle and WORD_CNT+1.
REQ-028 WAIT_RDY: RDY not seen within RDY_TIMEOUT cycles -> set ERR[0], go to RESTART, no WORD_DONE, no count; the word is discarded.
REQ-029 RESTART: lasts exactly one cycle; IO_BGN=0; go to IDLE.
REQ-030 IO_BGN SHALL be 1 in all states except RESTART.
REQ-031 All outputs SHALL be registered, with no combinational path from inputs.
REQ-032 ERR bits SHALL clear only on reset.
REQ-033 Latency: with the FIFO previously empty, a push at edge p gives IDLE pop at p+1, LOAD_N low during cycle p+1..p+2, and the first SI bit during p+2..p+3.

Reset
REQ-034 BGN=0 SHALL immediately force: state IDLE, FIFO empty (EMPTY=1, FULL=0), IO_BGN=0, LOAD_N=1, SI=0, BUSY=0, WORD_DONE=0, ERR=0, WORD_CNT=0.
REQ-035 After BGN rises, IO_BGN SHALL go to 1 at the first CLK edge.
REQ-036 Reset in mid-frame SHALL abort the frame and discard all FIFO contents.

Verification
REQ-037 Single word addr=0x1A5, data=0x3C with RDY returned 1 cycle after SHIFT ends -> LOAD_N low for 1 cycle; SI sequence 0,0,1,1,1,1,0,0,1,0,1,0,0,1,0,1,1; one WORD_DONE; WORD_CNT=1; IO_BGN low for 1 cycle; ERR=0.
REQ-038 Push 5 words back-to-back into the empty FIFO -> FULL asserted after the 4th (or 5th if the first is already popped); no drop expected; all words framed in order; WORD_CNT=5.
REQ-039 Push 6 words in 6 cycles while RDY is held 0 -> ERR[1]=1 for the dropped word; each frame times out after 8 WAIT_RDY cycles; ERR[0]=1; WORD_CNT=0.
REQ-040 RDY held 0 for 7 cycles, then 1 -> word confirmed and ERR[0]=0; at 9 cycles -> timeout.
REQ-041 BGN pulsed low at SHIFT bit 10 with 2 words queued -> all outputs return to reset values immediately; EMPTY=1; no further frames.
REQ-042 Push while FULL and popping in the same cycle -> word dropped, ERR[1]=1, occupancy decreases by 1.
